// File: rtl/track_controller.sv
// Top-level sequencer for the template-matching tracker: owns the tracked
// centre and bounding box, arms each correlation search and judges its result.
module track_controller #(
  parameter int VGA_WIDTH  = 640,
  parameter int VGA_HEIGHT = 480,
  parameter int BOX_WIDTH  = 20,
  parameter int INIT_X     = 320,
  parameter int INIT_Y     = 240,
  parameter int MAX_STEP   = 32,
  parameter int LOST_LIMIT = 4,
  parameter int TIMEOUT    = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        track_req,
  input  logic        cancel_req,
  input  logic        frame_rdy,
  input  logic        max_ready,
  input  logic [9:0]  max_x,
  input  logic [9:0]  max_y,
  output logic        tracking_mode,
  output logic        template_capture,
  output logic [9:0]  c_x,
  output logic [9:0]  c_y,
  output logic [9:0]  left,
  output logic [9:0]  right,
  output logic [9:0]  top,
  output logic [9:0]  bottom,
  output logic        lost,
  output logic [2:0]  miss_count,
  output logic [15:0] update_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_WAIT_FRAME,
    ST_SEARCH,
    ST_UPDATE,
    ST_LOST
  } state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [9:0] BOX_W   = 10'(BOX_WIDTH);
  localparam logic [9:0] INIT_CX = 10'(INIT_X);
  localparam logic [9:0] INIT_CY = 10'(INIT_Y);
  localparam logic [9:0] X_MIN   = 10'(BOX_WIDTH);
  localparam logic [9:0] X_MAX   = 10'(VGA_WIDTH - 1 - BOX_WIDTH);
  localparam logic [9:0] Y_MIN   = 10'(BOX_WIDTH);
  localparam logic [9:0] Y_MAX   = 10'(VGA_HEIGHT - 1 - BOX_WIDTH);
  localparam logic [10:0] STEP   = 11'(MAX_STEP);
  localparam logic [2:0] LIMIT   = 3'(LOST_LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t state, state_next;

  logic track_prev, frame_prev, max_prev;
  logic track_edge, frame_edge, max_edge;

  logic [CNT_W-1:0] search_cnt;
  logic             timeout_hit;

  logic [9:0] res_x, res_y;

  logic signed [10:0] diff_x, diff_y;
  logic [10:0]        dx, dy;
  logic               accept;
  logic [9:0]         cx_clamp, cy_clamp;
  logic [2:0]         miss_inc;
  logic               miss_to_lost;

  // Edge detection: an input counts only in the cycle it is first seen high.
  // NOTE: every register in this file is written with <= so all of them
  // sample the pre-edge values of each other; blocking here would race.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      track_prev <= 1'b0;
      frame_prev <= 1'b0;
      max_prev   <= 1'b0;
    end else begin
      track_prev <= track_req;
      frame_prev <= frame_rdy;
      max_prev   <= max_ready;
    end
  end

  assign track_edge = track_req & ~track_prev;
  assign frame_edge = frame_rdy & ~frame_prev;
  assign max_edge   = max_ready & ~max_prev;

  assign timeout_hit = (search_cnt == CNT_LAST);

  assign miss_inc     = (miss_count >= LIMIT) ? LIMIT : miss_count + 3'd1;
  assign miss_to_lost = (miss_inc == LIMIT);

  // Result judgement: distance is taken on 11-bit signed values so the
  // subtraction cannot wrap for any pair of 10-bit coordinates.
  always_comb begin
    diff_x = signed'({1'b0, res_x}) - signed'({1'b0, c_x});
    diff_y = signed'({1'b0, res_y}) - signed'({1'b0, c_y});
    dx     = (diff_x < 0) ? unsigned'(-diff_x) : unsigned'(diff_x);
    dy     = (diff_y < 0) ? unsigned'(-diff_y) : unsigned'(diff_y);
    accept = (dx <= STEP) && (dy <= STEP);
  end

  // The centre is kept far enough from the frame edge that the box fits.
  always_comb begin
    if (res_x < X_MIN)      cx_clamp = X_MIN;
    else if (res_x > X_MAX) cx_clamp = X_MAX;
    else                    cx_clamp = res_x;

    if (res_y < Y_MIN)      cy_clamp = Y_MIN;
    else if (res_y > Y_MAX) cy_clamp = Y_MAX;
    else                    cy_clamp = res_y;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned; without it this block would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:       if (track_edge) state_next = ST_CAPTURE;
      ST_CAPTURE:    state_next = ST_WAIT_FRAME;
      ST_WAIT_FRAME: if (frame_edge) state_next = ST_SEARCH;
      ST_SEARCH: begin
        if (max_edge)         state_next = ST_UPDATE;
        else if (timeout_hit) state_next = miss_to_lost ? ST_LOST : ST_WAIT_FRAME;
      end
      ST_UPDATE:     state_next = (accept || !miss_to_lost) ? ST_WAIT_FRAME : ST_LOST;
      ST_LOST:       if (track_edge) state_next = ST_CAPTURE;
      default:       state_next = ST_IDLE;
    endcase
    if (cancel_req) state_next = ST_IDLE;
  end

  always_comb begin
    tracking_mode    = 1'b0;
    template_capture = 1'b0;
    lost             = 1'b0;
    unique case (state)
      ST_CAPTURE:                        template_capture = 1'b1;
      ST_WAIT_FRAME, ST_SEARCH, ST_UPDATE: tracking_mode  = 1'b1;
      ST_LOST:                           lost             = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      search_cnt <= '0;
    end else if (state == ST_WAIT_FRAME && frame_edge) begin
      search_cnt <= '0;
    end else if (state == ST_SEARCH) begin
      search_cnt <= search_cnt + 1'b1;
    end
  end

  // NOTE: the result latch is pure datapath and is only read in UPDATE,
  // which is always preceded by a load, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == ST_SEARCH && max_edge) begin
      res_x <= max_x;
      res_y <= max_y;
    end
  end

  // Centre and box share one write enable so they always move together.
  always_ff @(posedge clk) begin
    if (!rst_n || cancel_req) begin
      c_x    <= INIT_CX;
      c_y    <= INIT_CY;
      left   <= INIT_CX - BOX_W;
      right  <= INIT_CX + BOX_W;
      top    <= INIT_CY - BOX_W;
      bottom <= INIT_CY + BOX_W;
    end else if (state == ST_UPDATE && accept) begin
      c_x    <= cx_clamp;
      c_y    <= cy_clamp;
      left   <= cx_clamp - BOX_W;
      right  <= cx_clamp + BOX_W;
      top    <= cy_clamp - BOX_W;
      bottom <= cy_clamp + BOX_W;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || cancel_req) begin
      miss_count <= '0;
    end else begin
      unique case (state)
        ST_CAPTURE: miss_count <= '0;
        ST_SEARCH:  if (!max_edge && timeout_hit) miss_count <= miss_inc;
        ST_UPDATE:  miss_count <= accept ? 3'd0 : miss_inc;
        default: ;
      endcase
    end
  end

  // Cancel leaves the accepted-update tally alone; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      update_count <= '0;
    end else if (!cancel_req && state == ST_UPDATE && accept) begin
      update_count <= update_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_track_controller.sv
// Scoreboard bench for track_controller: a behavioural tracker model predicts
// each visible output change; a negedge monitor pops and compares them.
module tb_track_controller;

  localparam int W  = 640;
  localparam int H  = 480;
  localparam int BW = 20;
  localparam int IX = 320;
  localparam int IY = 240;
  localparam int MS = 32;
  localparam int LL = 4;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        track_req, cancel_req, frame_rdy, max_ready;
  logic [9:0]  max_x, max_y;
  logic        tracking_mode, template_capture, lost;
  logic [9:0]  c_x, c_y, left, right, top, bottom;
  logic [2:0]  miss_count;
  logic [15:0] update_count;

  track_controller #(
    .VGA_WIDTH(W), .VGA_HEIGHT(H), .BOX_WIDTH(BW), .INIT_X(IX), .INIT_Y(IY),
    .MAX_STEP(MS), .LOST_LIMIT(LL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .track_req(track_req), .cancel_req(cancel_req),
    .frame_rdy(frame_rdy), .max_ready(max_ready), .max_x(max_x), .max_y(max_y),
    .tracking_mode(tracking_mode), .template_capture(template_capture),
    .c_x(c_x), .c_y(c_y), .left(left), .right(right), .top(top), .bottom(bottom),
    .lost(lost), .miss_count(miss_count), .update_count(update_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        tc, tm, lst;
    logic [9:0]  cx, cy, l, r, t, b;
    logic [2:0]  miss;
    logic [15:0] upd;
  } snap_t;

  typedef enum {M_IDLE, M_TRACK, M_LOST} mode_e;

  snap_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  mode_e m_mode;
  int    m_cx, m_cy, m_miss, m_upd;
  snap_t m_last;

  bit    mon_en = 1'b0;
  snap_t prev_obs, cur_obs, exp_obs;
  int    tc_width = 0;

  task automatic check(input string name, input bit ok, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  function automatic string fmt(input snap_t s);
    return $sformatf("tc=%0b tm=%0b lost=%0b c=(%0d,%0d) box=[%0d,%0d,%0d,%0d] miss=%0d upd=%0d",
                     s.tc, s.tm, s.lst, s.cx, s.cy, s.l, s.r, s.t, s.b, s.miss, s.upd);
  endfunction

  function automatic snap_t observe();
    snap_t s;
    s.tc = template_capture; s.tm = tracking_mode; s.lst = lost;
    s.cx = c_x; s.cy = c_y; s.l = left; s.r = right; s.t = top; s.b = bottom;
    s.miss = miss_count; s.upd = update_count;
    return s;
  endfunction

  function automatic int clip10(input int v);
    return (v < 0) ? 0 : (v > 1023) ? 1023 : v;
  endfunction

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  // ---------------- behavioural model ----------------
  function automatic snap_t model_snap(input bit capture);
    snap_t s;
    s.tc  = capture;
    s.tm  = !capture && (m_mode == M_TRACK);
    s.lst = !capture && (m_mode == M_LOST);
    s.cx  = 10'(m_cx);      s.cy = 10'(m_cy);
    s.l   = 10'(m_cx - BW); s.r  = 10'(m_cx + BW);
    s.t   = 10'(m_cy - BW); s.b  = 10'(m_cy + BW);
    s.miss = 3'(m_miss);
    s.upd  = 16'(m_upd);
    return s;
  endfunction

  task automatic push_snap(input bit capture);
    snap_t s;
    s = model_snap(capture);
    if (s != m_last) begin
      exp_q.push_back(s);
      m_last = s;
    end
  endtask

  task automatic model_home();
    m_mode = M_IDLE; m_cx = IX; m_cy = IY; m_miss = 0;
  endtask

  task automatic model_miss();
    m_miss = (m_miss < LL) ? m_miss + 1 : LL;
    if (m_miss == LL) m_mode = M_LOST;
  endtask

  task automatic model_result(input int mx, input int my);
    int ax, ay;
    ax = (mx > m_cx) ? mx - m_cx : m_cx - mx;
    ay = (my > m_cy) ? my - m_cy : m_cy - my;
    if (ax <= MS && ay <= MS) begin
      m_cx   = clamp(mx, BW, W - 1 - BW);
      m_cy   = clamp(my, BW, H - 1 - BW);
      m_miss = 0;
      m_upd  = (m_upd + 1) % 65536;
    end else begin
      model_miss();
    end
    push_snap(1'b0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      cur_obs = observe();
      if (cur_obs != prev_obs) begin
        if (exp_q.size() == 0) begin
          check("unexpected_change", 1'b0, $sformatf("got %s, none expected", fmt(cur_obs)));
        end else begin
          exp_obs = exp_q.pop_front();
          check("snapshot", cur_obs == exp_obs,
                $sformatf("got %s want %s", fmt(cur_obs), fmt(exp_obs)));
        end
        prev_obs = cur_obs;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (template_capture) tc_width++;
      else if (tc_width != 0) begin
        check("capture_width", tc_width == 1, $sformatf("got %0d cycles want 1", tc_width));
        tc_width = 0;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_track();
    @(negedge clk);
    track_req = 1'b1;
    if (m_mode != M_TRACK) begin
      push_snap(1'b1);
      m_mode = M_TRACK;
      m_miss = 0;
      push_snap(1'b0);
    end
    @(negedge clk);
    track_req = 1'b0;
    settle(3);
  endtask

  task automatic do_cancel();
    @(negedge clk);
    cancel_req = 1'b1;
    model_home();
    push_snap(1'b0);
    @(negedge clk);
    cancel_req = 1'b0;
    settle(3);
  endtask

  // Frame edge, then a result k cycles later; k > TO means the search times out.
  task automatic do_frame(input int mx, input int my, input int k);
    bit   active;
    bit   timed;
    logic [2:0] old_miss;
    active   = (m_mode == M_TRACK);
    timed    = active && (k > TO);
    old_miss = 3'(m_miss);
    if (timed) begin
      model_miss();
      push_snap(1'b0);
    end
    @(negedge clk);
    frame_rdy = 1'b1;
    for (int j = 1; j <= TO + 1; j++) begin
      @(negedge clk);
      if (j == 1) frame_rdy = 1'b0;
      if (timed && j == TO)
        check("no_early_timeout", miss_count == old_miss,
              $sformatf("got miss=%0d want %0d", miss_count, old_miss));
      if (timed && j == TO + 1)
        check("timeout_miss", miss_count == 3'(m_miss),
              $sformatf("got miss=%0d want %0d", miss_count, m_miss));
      if (j == k) begin
        max_x = 10'(mx);
        max_y = 10'(my);
        max_ready = 1'b1;
        if (active && !timed) model_result(mx, my);
      end else begin
        max_ready = 1'b0;
        if (j == k + 1) begin
          max_x = 10'($urandom_range(0, 1023));
          max_y = 10'($urandom_range(0, 1023));
        end
      end
    end
    max_ready = 1'b0;
    settle(3);
  endtask

  int offs[5] = '{0, 32, -32, 33, -33};

  initial begin
    rst_n = 1'b0; track_req = 1'b0; cancel_req = 1'b0;
    frame_rdy = 1'b0; max_ready = 1'b0; max_x = '0; max_y = '0;
    model_home();
    m_upd = 0;
    m_last = model_snap(1'b0);
    settle(3);
    rst_n = 1'b1;
    @(negedge clk);
    cur_obs = observe();
    check("reset_state", cur_obs == m_last,
          $sformatf("got %s want %s", fmt(cur_obs), fmt(m_last)));
    prev_obs = cur_obs;
    mon_en   = 1'b1;

    do_track();
    do_frame(340, 230, 5);

    // Walk right to 610, then overshoot the right clamp.
    while (m_cx + 32 <= 610) do_frame(m_cx + 32, m_cy, 3);
    if (m_cx != 610) do_frame(610, m_cy, 3);
    do_frame(630, m_cy, 3);
    check("clamp_right", c_x == 10'd619 && right == 10'd639,
          $sformatf("got c_x=%0d right=%0d want 619/639", c_x, right));

    repeat (9)  do_frame(m_cx, m_cy + 32, 2);
    repeat (22) do_frame(clip10(m_cx - 32), clip10(m_cy - 32), 2);

    repeat (4) do_frame(m_cx + 50, m_cy, 3);
    do_frame(m_cx, m_cy, 3);
    do_track();

    do_frame(0, 0, TO + 1);
    do_frame(m_cx + 1, m_cy, TO);

    // Cancel coincident with a result edge during SEARCH.
    @(negedge clk); frame_rdy = 1'b1;
    @(negedge clk); frame_rdy = 1'b0;
    settle(3);
    cancel_req = 1'b1; max_ready = 1'b1; max_x = 10'(m_cx + 5); max_y = 10'(m_cy);
    model_home();
    push_snap(1'b0);
    @(negedge clk); cancel_req = 1'b0; max_ready = 1'b0;
    settle(3);

    // Reset in the middle of a search.
    do_track();
    do_frame(m_cx + 3, m_cy - 3, 4);
    @(negedge clk); frame_rdy = 1'b1;
    @(negedge clk); frame_rdy = 1'b0;
    settle(4);
    rst_n = 1'b0;
    model_home();
    m_upd = 0;
    push_snap(1'b0);
    @(negedge clk); rst_n = 1'b1;
    settle(3);

    for (int i = 0; i < 200; i++) begin
      int op;
      op = int'($urandom_range(0, 99));
      if (op < 10)      do_track();
      else if (op < 13) do_cancel();
      else if (op < 20) do_frame(m_cx, m_cy, TO + int'($urandom_range(1, 2)));
      else if (op < 32) do_frame(clip10(m_cx + offs[$urandom_range(0, 4)]),
                                 clip10(m_cy + offs[$urandom_range(0, 4)]),
                                 int'($urandom_range(1, TO)));
      else              do_frame(clip10(m_cx + int'($urandom_range(0, 80)) - 40),
                                 clip10(m_cy + int'($urandom_range(0, 80)) - 40),
                                 int'($urandom_range(1, TO)));
    end

    settle(5);
    check("queue_drained", exp_q.size() == 0,
          $sformatf("got %0d pending want 0", exp_q.size()));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
